qspi_xip_ctrl: RTL

- Parametrised read-only QSPI flash controller for execute-in-place (XIP), the next generation of the current fixed 24-bit, single-mode QSPI read path.
- Sits behind a tlul_sram_adapter and serves its req/gnt/rvalid interface, issuing Fast Read commands to an external SPI-mode-0 flash.
- New over the previous generation:
  - configurable address width, data width, dummy cycles and SCK divider;
  - single or quad data mode;
  - sequential-burst continuation, which keeps CS low and skips command/address for consecutive word reads;
  - error response on writes.

---
 rtl/qspi_pkg.sv | 24 ++
 rtl/qspi_sck_gen.sv | 35 +++
 rtl/qspi_xip_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/qspi_pkg.sv
// rtl/qspi_pkg.sv - shared types, opcodes and timing helper for the QSPI XIP controller
package qspi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        RESP,
        HOLD,
        CSHIGH
    } qspi_state_e;

    localparam logic [7:0] QSPI_CMD_FAST_READ     = 8'h0B;
    localparam logic [7:0] QSPI_CMD_QUAD_OUT_READ = 8'h6B;

    // SCK periods of one full read transaction (command + address + dummy + data)
    function automatic int unsigned qspi_nsck(input int unsigned addr_w, input int unsigned data_w,
                                              input int unsigned dummy, input bit quad);
        return 8 + addr_w + dummy + (quad ? data_w / 4 : data_w);
    endfunction

endpackage

// File: rtl/qspi_sck_gen.sv
// rtl/qspi_sck_gen.sv - SCK divider with one-cycle rise/fall strobes, held low when disabled
module qspi_sck_gen #(
    parameter int ClkDiv = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en,
    output logic sck,
    output logic rise,
    output logic fall
);

    localparam int CntW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;

    logic [CntW-1:0] cnt;
    logic            tick;

    // rise/fall flag the clk_i edge at which SCK changes level
    assign tick = en && (cnt == CntW'(ClkDiv - 1));
    assign rise = tick && !sck;
    assign fall = tick && sck;

    always_ff @(posedge clk_i) begin
        if (rst_i || !en) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (tick) begin
            cnt <= '0;
            sck <= ~sck;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/qspi_xip_ctrl.sv
// rtl/qspi_xip_ctrl.sv - read-only QSPI execute-in-place controller with sequential-burst continuation
module qspi_xip_ctrl
    import qspi_pkg::*;
#(
    parameter int AddrW        = 24,
    parameter int DataW        = 32,
    parameter int DummyCycles  = 8,
    parameter int ClkDiv       = 1,
    parameter int QuadData     = 1,
    parameter int HoldCycles   = 16,
    parameter int CsHighCycles = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] addr_i,
    output logic             gnt_o,
    output logic             rvalid_o,
    output logic [DataW-1:0] rdata_o,
    output logic             rerror_o,
    output logic             busy_o,
    input  logic [3:0]       qspi_i,
    output logic [3:0]       qspi_o,
    output logic [3:0]       qspi_oe,
    output logic             qspi_csb,
    output logic             qspi_clk
);

    localparam int         ByteW  = DataW / 8;
    localparam int         NData  = (QuadData != 0) ? DataW / 4 : DataW;
    localparam int         TxW    = 8 + AddrW;
    localparam int         CntW   = 16;
    localparam logic [7:0] Opcode = (QuadData != 0) ? QSPI_CMD_QUAD_OUT_READ : QSPI_CMD_FAST_READ;
    localparam int         CsLoad = (CsHighCycles > 0) ? CsHighCycles - 1 : 0;

    qspi_state_e      state, state_n;
    logic [CntW-1:0]  bit_cnt;
    logic [CntW-1:0]  cnt;
    logic [TxW-1:0]   tx_sr;
    logic [DataW-1:0] rx_sr;
    logic [DataW-1:0] rx_le;
    logic [AddrW-1:0] last_addr;
    logic [AddrW-1:0] addr_al;
    logic [AddrW-1:0] seq_next;
    logic             seq_match;
    logic             sck_en, rise, fall, drive;

    assign addr_al   = addr_i & ~AddrW'(ByteW - 1);
    assign seq_next  = last_addr + AddrW'(ByteW);
    // a wrap to address 0 never continues the burst
    assign seq_match = !we_i && (addr_al == seq_next) && (seq_next != '0);

    assign sck_en   = (state == CMD) || (state == ADDR) || (state == DUMMY) || (state == DATA);
    assign drive    = (state == CMD) || (state == ADDR);
    assign qspi_o   = {3'b000, drive & tx_sr[TxW-1]};
    assign qspi_oe  = {3'b000, drive};
    assign qspi_csb = (state == IDLE) || (state == CSHIGH);
    assign busy_o   = (state != IDLE);

    qspi_sck_gen #(.ClkDiv(ClkDiv)) u_sck_gen (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (sck_en),
        .sck   (qspi_clk),
        .rise  (rise),
        .fall  (fall)
    );

    always_comb begin
        state_n = state;
        gnt_o   = 1'b0;
        unique case (state)
            IDLE: if (req_i) begin
                gnt_o = 1'b1;
                if (!we_i) state_n = CMD;
            end
            CMD:   if (fall && bit_cnt == CntW'(7)) state_n = ADDR;
            ADDR:  if (fall && bit_cnt == CntW'(AddrW - 1)) state_n = (DummyCycles > 0) ? DUMMY : DATA;
            DUMMY: if (fall && bit_cnt == CntW'(DummyCycles - 1)) state_n = DATA;
            DATA:  if (fall && bit_cnt == CntW'(NData - 1)) state_n = RESP;
            RESP:  state_n = HOLD;
            HOLD: begin
                if (req_i && seq_match) begin
                    gnt_o   = 1'b1;
                    state_n = DATA;
                end else if (req_i || cnt <= CntW'(1)) begin
                    state_n = CSHIGH;
                end
            end
            CSHIGH: if (cnt == '0) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (rst_i) gnt_o = 1'b0;
    end

    // first byte on the wire lands in the top of rx_sr; repack little-endian
    always_comb begin
        rx_le = '0;
        for (int i = 0; i < ByteW; i++) begin
            rx_le[8*i +: 8] = rx_sr[DataW-1-8*i -: 8];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            cnt       <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            last_addr <= '0;
            rvalid_o  <= 1'b0;
            rerror_o  <= 1'b0;
            rdata_o   <= '0;
        end else begin
            state    <= state_n;
            rvalid_o <= 1'b0;
            rerror_o <= 1'b0;

            if (state != state_n) bit_cnt <= '0;
            else if (fall)        bit_cnt <= bit_cnt + 1'b1;

            if (gnt_o && !we_i) begin
                last_addr <= addr_al;
                tx_sr     <= {Opcode, addr_al};
            end else if (fall && drive) begin
                tx_sr <= tx_sr << 1;
            end

            if (rise && state == DATA) begin
                rx_sr <= (QuadData != 0) ? {rx_sr[DataW-5:0], qspi_i}
                                         : {rx_sr[DataW-2:0], qspi_i[1]};
            end

            if (gnt_o && we_i) begin
                rvalid_o <= 1'b1;
                rerror_o <= 1'b1;
                rdata_o  <= '0;
            end

            if (state == RESP) begin
                rvalid_o <= 1'b1;
                rdata_o  <= rx_le;
                cnt      <= CntW'(HoldCycles);
            end else if (state == HOLD) begin
                cnt <= (state_n == CSHIGH) ? CntW'(CsLoad) : cnt - 1'b1;
            end else if (state == CSHIGH) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule
